// File: rtl/code_output_packer.sv
// ============================================================================
// Module   : code_output_packer
// Brief    : Packs variable-length codewords MSB-first into OUT_W-bit words;
//            flush drains the buffer and zero-pads the final word.
//            Optional output_last port enabled by `OUTPUT_PACKER_LAST_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module code_output_packer #(
    parameter int CODE_WIDTH       = 39,
    parameter int BIT_AMT_WIDTH    = 6,
    parameter int OUTPUT_WIDTH_LOG = 5
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    output logic                               flushed,
    input  logic [CODE_WIDTH-1:0]              input_code_data,
    input  logic [BIT_AMT_WIDTH-1:0]           input_length_data,
    input  logic                               input_valid,
    output logic                               input_ready,
    output logic [(2**OUTPUT_WIDTH_LOG)-1:0]   output_data,
    output logic                               output_valid,
    input  logic                               output_ready
`ifdef OUTPUT_PACKER_LAST_EN
    ,
    output logic                               output_last
`endif
);

    localparam int c_OUT_W = 2**OUTPUT_WIDTH_LOG;
    localparam int c_BUF_W = c_OUT_W + CODE_WIDTH;
    localparam int c_CNT_W = $clog2(c_BUF_W + 1);
    localparam logic [c_CNT_W-1:0] c_OUT_CNT  = c_CNT_W'(c_OUT_W);
    localparam logic [c_CNT_W-1:0] c_BUF_CNT  = c_CNT_W'(c_BUF_W);
    localparam logic [c_CNT_W-1:0] c_CODE_CNT = c_CNT_W'(CODE_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FLUSH = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_BUF_W-1:0]   r_buf;
    logic [c_BUF_W-1:0]   w_buf_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic [c_CNT_W-1:0]   w_len;
    logic [c_CNT_W-1:0]   w_shamt;
    logic [c_BUF_W-1:0]   w_mask;
    logic [c_BUF_W-1:0]   w_ins;
    logic                 w_in_hs;
    logic                 w_out_hs;

    // Over-long length fields saturate at the codeword width.
    assign w_len = (32'(input_length_data) > 32'(CODE_WIDTH)) ? c_CODE_CNT
                                                              : c_CNT_W'(input_length_data);
    // Place the code so its top bit lands just below the cnt occupied bits.
    assign w_shamt = c_BUF_CNT - r_cnt - w_len;
    assign w_mask  = ~({c_BUF_W{1'b1}} << w_len);
    assign w_ins   = (c_BUF_W'(input_code_data) & w_mask) << w_shamt;

    assign input_ready  = (r_state == S_IDLE) && (r_cnt < c_OUT_CNT);
    assign output_valid = (r_cnt >= c_OUT_CNT) || ((r_state == S_FLUSH) && (r_cnt != '0));
    assign output_data  = r_buf[c_BUF_W-1 -: c_OUT_W];
    assign flushed      = (r_state == S_DONE);
    assign w_in_hs      = input_valid && input_ready;
    assign w_out_hs     = output_valid && output_ready;

`ifdef OUTPUT_PACKER_LAST_EN
    assign output_last = output_valid && (r_state == S_FLUSH) && (r_cnt <= c_OUT_CNT);
`endif

    always_comb begin
        w_buf_nxt   = r_buf;
        w_cnt_nxt   = r_cnt;
        w_state_nxt = r_state;

        if (w_in_hs) begin
            w_buf_nxt = r_buf | w_ins;
            w_cnt_nxt = r_cnt + w_len;
        end else if (w_out_hs) begin
            w_buf_nxt = r_buf << c_OUT_W;
            w_cnt_nxt = (r_cnt >= c_OUT_CNT) ? (r_cnt - c_OUT_CNT) : '0;
        end

        case (r_state)
            S_IDLE: begin
                if (flush) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            // Leave as soon as the last word is taken so flushed follows it directly.
            S_FLUSH: begin
                if (w_cnt_nxt == '0) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_buf_nxt   = '0;
                w_cnt_nxt   = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_buf   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_buf   <= w_buf_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_code_output_packer.sv
// ============================================================================
// Module   : tb_code_output_packer
// Brief    : Scoreboard bench for code_output_packer against a bit-queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_code_output_packer;

    localparam int CW = 39;
    localparam int LW = 6;
    localparam int OW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          flushed;
    logic [CW-1:0] code = '0;
    logic [LW-1:0] len = '0;
    logic          input_valid = 1'b0;
    logic          input_ready;
    logic [OW-1:0] output_data;
    logic          output_valid;
    logic          output_ready = 1'b1;
`ifdef OUTPUT_PACKER_LAST_EN
    logic          olast;
    bit            seen_last[$];
`endif

    int            total = 0;
    int            bad = 0;
    bit            bq[$];
    logic [OW-1:0] seen_q[$];
    bit            flush_pend = 1'b0;
    int            rdy_mode = 0;
    logic [OW-1:0] m_exp;
    int            m_n;

    always #5 clk = ~clk;

    code_output_packer dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .flushed           (flushed),
        .input_code_data   (code),
        .input_length_data (len),
        .input_valid       (input_valid),
        .input_ready       (input_ready),
        .output_data       (output_data),
        .output_valid      (output_valid),
        .output_ready      (output_ready)
`ifdef OUTPUT_PACKER_LAST_EN
        ,
        .output_last       (olast)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       output_ready = 1'b1;
            1:       output_ready = 1'($urandom_range(0, 1));
            default: output_ready = 1'b0;
        endcase
    end

    // Monitor: each accepted word takes the next OW bits of the model stream.
    always @(negedge clk) begin
        if (rst === 1'b1 && output_valid === 1'b1 && output_ready === 1'b1) begin
            if (bq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got %0h required no word", output_data);
            end else begin
                if (bq.size() < OW && !flush_pend) begin
                    total++;
                    bad++;
                    $display("FAIL early_word: got %0h with %0d bits pending, required no word",
                             output_data, bq.size());
                end
                m_exp = '0;
                m_n   = (bq.size() < OW) ? bq.size() : OW;
                for (int i = 0; i < m_n; i++) m_exp[OW-1-i] = bq.pop_front();
                check("word", 64'(output_data), 64'(m_exp));
`ifdef OUTPUT_PACKER_LAST_EN
                check("last", 64'(olast), 64'(flush_pend && bq.size() == 0));
                seen_last.push_back(olast);
`endif
                seen_q.push_back(output_data);
            end
        end
    end

    task automatic send(input logic [CW-1:0] c, input int l, input int gap);
        int  waited = 0;
        bit  done = 0;
        int  eff;
        code        = c;
        len         = LW'(l);
        input_valid = 1'b1;
        while (!done && waited < 500) begin
            @(negedge clk);
            if (input_ready) begin
                eff = (l > CW) ? CW : l;
                for (int i = eff - 1; i >= 0; i--) bq.push_back(c[i]);
                done = 1;
            end
            tick();
            waited++;
        end
        input_valid = 1'b0;
        if (!done) check("send_timeout", 64'(0), 64'(1));
        repeat (gap) tick();
    endtask

    task automatic do_flush(input int exp_delay);
        int k = 0;
        bit seen = 0;
        flush = 1'b1;
        tick();
        flush      = 1'b0;
        flush_pend = 1'b1;
        while (!seen && k < 3000) begin
            @(negedge clk);
            k++;
            if (flushed) seen = 1;
            else tick();
        end
        if (!seen) begin
            check("flush_timeout", 64'(0), 64'(1));
        end else begin
            flush_pend = 1'b0;
            if (exp_delay > 0) check("flushed_delay", 64'(k), 64'(exp_delay));
            check("flush_drained", 64'(bq.size()), 64'(0));
            check("done_no_valid", 64'(output_valid), 64'(0));
            tick();
            @(negedge clk);
            check("flushed_single", 64'(flushed), 64'(0));
            tick();
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_out_valid", 64'(output_valid), 64'(0));
        check("rst_in_ready", 64'(input_ready), 64'(1));
        check("rst_flushed", 64'(flushed), 64'(0));
        rst = 1'b1;
        tick();

        // Four bytes form one word, then nothing remains
        seen_q.delete();
        send(39'hAA, 8, 0); send(39'hBB, 8, 0); send(39'hCC, 8, 0); send(39'hDD, 8, 0);
        repeat (3) tick();
        check("t2_count", 64'(seen_q.size()), 64'(1));
        if (seen_q.size() > 0) check("t2_word", 64'(seen_q[0]), 64'h0000_0000_AABB_CCDD);
        do_flush(2);
        check("t2_no_extra", 64'(seen_q.size()), 64'(1));

        // Full-width code spills across two words
        seen_q.delete();
`ifdef OUTPUT_PACKER_LAST_EN
        seen_last.delete();
`endif
        send(39'h7F_FFFF_FFFF, 39, 0);
        do_flush(0);
        check("t3_count", 64'(seen_q.size()), 64'(2));
        if (seen_q.size() == 2) begin
            check("t3_w0", 64'(seen_q[0]), 64'h0000_0000_FFFF_FFFF);
            check("t3_w1", 64'(seen_q[1]), 64'h0000_0000_FE00_0000);
        end
`ifdef OUTPUT_PACKER_LAST_EN
        if (seen_last.size() == 2) begin
            check("t3_last0", 64'(seen_last[0]), 64'(0));
            check("t3_last1", 64'(seen_last[1]), 64'(1));
        end
`endif

        // Partial word padded by flush
        seen_q.delete();
        send(39'hABC, 12, 0);
        do_flush(2);
        check("t4_count", 64'(seen_q.size()), 64'(1));
        if (seen_q.size() > 0) check("t4_word", 64'(seen_q[0]), 64'h0000_0000_ABC0_0000);

        // Backpressure holds the word and blocks input
        seen_q.delete();
        rdy_mode = 2;
        tick(); tick();
        send(39'h11, 8, 0); send(39'h22, 8, 0); send(39'h33, 8, 0); send(39'h44, 8, 0);
        input_valid = 1'b1;
        code        = 39'h55;
        len         = 6'd8;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", 64'(output_valid), 64'(1));
            check("bp_in_ready", 64'(input_ready), 64'(0));
            check("bp_data", 64'(output_data), 64'h0000_0000_1122_3344);
            tick();
        end
        input_valid = 1'b0;
        rdy_mode = 0;
        repeat (4) tick();
        check("bp_count", 64'(seen_q.size()), 64'(1));
        do_flush(2);

        // Reset mid-operation discards buffered bits
        send(39'h12345, 20, 0);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", 64'(output_valid), 64'(0));
        check("mid_rst_ready", 64'(input_ready), 64'(1));
        check("mid_rst_flushed", 64'(flushed), 64'(0));
        bq.delete();
        tick();
        rst = 1'b1;
        tick();
        seen_q.delete();
        do_flush(2);
        check("empty_flush_words", 64'(seen_q.size()), 64'(0));

        // Random valid/ready with counting codes and cycling lengths
        rdy_mode = 1;
        for (int i = 1; i <= 300; i++) send(CW'(i), ((i - 1) % 5) + 1, $urandom_range(0, 2));
        do_flush(0);

        // Random codes, including zero and over-long lengths
        for (int i = 0; i < 200; i++) begin
            send({$urandom, $urandom}, $urandom_range(0, 63), $urandom_range(0, 1));
            if (i % 50 == 49) do_flush(0);
        end
        rdy_mode = 0;
        tick();
        check("final_model_empty", 64'(bq.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
